car_park_ctrl: RTL and testbench

//  Parametrised car-park controller: N_SLOTS places, one entry lane, one exit lane.

---
 rtl/car_park_ctrl_pkg.sv | 21 ++
 rtl/car_park_ctrl_if.sv | 37 +++
 rtl/car_park_ctrl_slot_table.sv | 86 ++++++++
 rtl/car_park_ctrl.sv | 178 +++++++++++++++++
 tb/tb_car_park_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_park_ctrl_pkg.sv
// Shared types for the car-park controller: FSM encodings and error-pulse bit positions.
package car_park_ctrl_pkg;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_OPEN = 2'd1,
    E_HOLD = 2'd2
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_FEE  = 2'd1,
    X_OPEN = 2'd2,
    X_HOLD = 2'd3
  } exit_state_t;

  localparam int unsigned ERR_W       = 2;
  localparam int unsigned ERR_BAR_TO  = 0;
  localparam int unsigned ERR_BAD_TKT = 1;

endpackage

// File: rtl/car_park_ctrl_if.sv
// Sensor / payment-terminal bundle of the car-park controller; slave side is the controller.
interface car_park_ctrl_if
  import car_park_ctrl_pkg::*;
#(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned FEE_W   = 24
);
  localparam int unsigned ID_W = $clog2(N_SLOTS);

  logic              tick;
  logic              in_req;
  logic              in_pass;
  logic              bar_in;
  logic              tkt_valid;
  logic [ID_W-1:0]   tkt_id;
  logic              out_req;
  logic [ID_W-1:0]   out_id;
  logic [FEE_W-1:0]  fee;
  logic              fee_valid;
  logic              pay;
  logic              out_pass;
  logic              bar_out;
  logic [ID_W:0]     free_cnt;
  logic              full;
  logic [ERR_W-1:0]  err;

  modport master (
    output tick, in_req, in_pass, out_req, out_id, pay, out_pass,
    input  bar_in, tkt_valid, tkt_id, fee, fee_valid, bar_out, free_cnt, full, err
  );

  modport slave (
    input  tick, in_req, in_pass, out_req, out_id, pay, out_pass,
    output bar_in, tkt_valid, tkt_id, fee, fee_valid, bar_out, free_cnt, full, err
  );

endinterface

// File: rtl/car_park_ctrl_slot_table.sv
// Slot occupancy table: valid bits, entry timestamps, lowest-free encoder and free count.
module car_park_ctrl_slot_table #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned TIME_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_alloc_en,
  input  logic [TIME_W-1:0]        i_alloc_time,
  output logic [$clog2(N_SLOTS)-1:0] o_free_id_c,
  input  logic                     i_rel_a_en,
  input  logic [$clog2(N_SLOTS)-1:0] i_rel_a_id,
  input  logic                     i_rel_b_en,
  input  logic [$clog2(N_SLOTS)-1:0] i_rel_b_id,
  input  logic [$clog2(N_SLOTS)-1:0] i_rd_id,
  output logic                     o_rd_valid_c,
  output logic [TIME_W-1:0]        o_rd_time_c,
  output logic [$clog2(N_SLOTS):0] o_free_cnt,
  output logic                     o_full
);
  localparam int unsigned ID_W  = $clog2(N_SLOTS);
  localparam int unsigned CNT_W = ID_W + 1;

  logic [N_SLOTS-1:0] r_valid;
  logic [TIME_W-1:0]  r_tstamp [N_SLOTS];
  logic [CNT_W-1:0]   r_free_cnt;
  logic               r_full;

  logic [N_SLOTS-1:0] w_valid_nxt;
  logic [ID_W-1:0]    w_free_id;
  logic               w_any_free;
  logic               w_alloc;
  logic [CNT_W-1:0]   w_used;

  // Lowest-index free slot, taken from the pre-cycle valid vector
  always_comb begin
    w_free_id  = '0;
    w_any_free = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_id  = ID_W'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_alloc = i_alloc_en && w_any_free;

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_alloc)    w_valid_nxt[w_free_id]  = 1'b1;
    if (i_rel_a_en) w_valid_nxt[i_rel_a_id] = 1'b0;
    if (i_rel_b_en) w_valid_nxt[i_rel_b_id] = 1'b0;
  end

  always_comb begin
    w_used = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_used = w_used + CNT_W'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_free_cnt <= CNT_W'(N_SLOTS);
      r_full     <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_free_cnt <= CNT_W'(N_SLOTS) - w_used;
      r_full     <= (w_used == CNT_W'(N_SLOTS));
    end
  end

  // Timestamps are only meaningful behind a set valid bit, so they need no reset
  always_ff @(posedge clk) begin
    if (w_alloc) r_tstamp[w_free_id] <= i_alloc_time;
  end

  assign o_free_id_c  = w_free_id;
  assign o_rd_valid_c = r_valid[i_rd_id];
  assign o_rd_time_c  = r_tstamp[i_rd_id];
  assign o_free_cnt   = r_free_cnt;
  assign o_full       = r_full;

endmodule

// File: rtl/car_park_ctrl.sv
// Car-park controller: ticketed entry lane, fee-gated exit lane, global tick time base.
module car_park_ctrl
  import car_park_ctrl_pkg::*;
#(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned TIME_W  = 16,
  parameter int unsigned RATE    = 1,
  parameter int unsigned FEE_W   = 24,
  parameter int unsigned BAR_TO  = 1024
) (
  input logic             clk,
  input logic             rst,
  car_park_ctrl_if.slave  bus
);
  localparam int unsigned ID_W   = $clog2(N_SLOTS);
  localparam int unsigned CNT_W  = ID_W + 1;
  localparam int unsigned BTO_W  = $clog2(BAR_TO + 1);
  localparam int unsigned PROD_W = TIME_W + 32 + FEE_W;
  localparam logic [FEE_W-1:0] FEE_MAX = '1;

  entry_state_t       r_ent_state, w_ent_nxt;
  exit_state_t        r_ext_state, w_ext_nxt;
  logic [TIME_W-1:0]  r_time;
  logic [BTO_W-1:0]   r_bar_cnt;
  logic [ID_W-1:0]    r_tkt_id;
  logic               r_tkt_valid;
  logic [ID_W-1:0]    r_ext_id;
  logic [FEE_W-1:0]   r_fee;
  logic [ERR_W-1:0]   r_err;

  logic               w_alloc, w_timeout;
  logic               w_accept, w_bad, w_exit_rel;
  logic               w_bar_in, w_bar_out, w_fee_valid;
  logic [ID_W-1:0]    w_free_id;
  logic               w_rd_valid;
  logic [TIME_W-1:0]  w_rd_time;
  logic [CNT_W-1:0]   w_free_cnt;
  logic               w_full;
  logic [TIME_W-1:0]  w_elapsed;
  logic [PROD_W-1:0]  w_prod;
  logic [FEE_W-1:0]   w_fee;

  car_park_ctrl_slot_table #(
    .N_SLOTS (N_SLOTS),
    .TIME_W  (TIME_W)
  ) u_slots (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_en   (w_alloc),
    .i_alloc_time (r_time),
    .o_free_id_c  (w_free_id),
    .i_rel_a_en   (w_timeout),
    .i_rel_a_id   (r_tkt_id),
    .i_rel_b_en   (w_exit_rel),
    .i_rel_b_id   (r_ext_id),
    .i_rd_id      (bus.out_id),
    .o_rd_valid_c (w_rd_valid),
    .o_rd_time_c  (w_rd_time),
    .o_free_cnt   (w_free_cnt),
    .o_full       (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent_state <= E_IDLE;
      r_ext_state <= X_IDLE;
    end else begin
      r_ent_state <= w_ent_nxt;
      r_ext_state <= w_ext_nxt;
    end
  end

  // Entry lane: one ticket per car presence, bar released on pass or timeout
  always_comb begin
    w_ent_nxt = r_ent_state;
    w_alloc   = 1'b0;
    w_timeout = 1'b0;
    case (r_ent_state)
      E_IDLE: if (bus.in_req && !w_full) begin
        w_alloc   = 1'b1;
        w_ent_nxt = E_OPEN;
      end
      E_OPEN: if (bus.in_pass) begin
        w_ent_nxt = E_HOLD;
      end else if (r_bar_cnt == BTO_W'(BAR_TO - 1)) begin
        w_timeout = 1'b1;
        w_ent_nxt = E_HOLD;
      end
      E_HOLD: if (!bus.in_req) w_ent_nxt = E_IDLE;
      default: w_ent_nxt = E_IDLE;
    endcase
  end

  // Exit lane: validate ticket, wait for payment, open bar, free slot on pass
  always_comb begin
    w_ext_nxt  = r_ext_state;
    w_accept   = 1'b0;
    w_bad      = 1'b0;
    w_exit_rel = 1'b0;
    case (r_ext_state)
      X_IDLE: if (bus.out_req) begin
        if (w_rd_valid) begin
          w_accept  = 1'b1;
          w_ext_nxt = X_FEE;
        end else begin
          w_bad     = 1'b1;
          w_ext_nxt = X_HOLD;
        end
      end
      X_FEE: if (bus.pay) begin
        w_ext_nxt = X_OPEN;
      end else if (!bus.out_req) begin
        w_ext_nxt = X_IDLE;
      end
      X_OPEN: if (bus.out_pass) begin
        w_exit_rel = 1'b1;
        w_ext_nxt  = X_HOLD;
      end
      X_HOLD: if (!bus.out_req) w_ext_nxt = X_IDLE;
      default: w_ext_nxt = X_IDLE;
    endcase
  end

  always_comb begin
    w_bar_in    = 1'b0;
    w_bar_out   = 1'b0;
    w_fee_valid = 1'b0;
    if (r_ent_state == E_OPEN) w_bar_in    = 1'b1;
    if (r_ext_state == X_OPEN) w_bar_out   = 1'b1;
    if (r_ext_state == X_FEE)  w_fee_valid = 1'b1;
  end

  // Modular subtraction handles time-counter wrap; zero elapsed still bills one tick
  always_comb begin
    w_elapsed = r_time - w_rd_time;
    if (w_elapsed == '0) w_elapsed = TIME_W'(1);
    w_prod = PROD_W'(w_elapsed) * PROD_W'(RATE);
    w_fee  = (w_prod > PROD_W'(FEE_MAX)) ? FEE_MAX : FEE_W'(w_prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_time      <= '0;
      r_bar_cnt   <= '0;
      r_tkt_id    <= '0;
      r_tkt_valid <= 1'b0;
      r_ext_id    <= '0;
      r_fee       <= '0;
      r_err       <= '0;
    end else begin
      r_time      <= r_time + TIME_W'(bus.tick);
      r_tkt_valid <= w_alloc;
      if (w_alloc) begin
        r_tkt_id  <= w_free_id;
        r_bar_cnt <= '0;
      end else if (r_ent_state == E_OPEN) begin
        r_bar_cnt <= r_bar_cnt + BTO_W'(1);
      end
      if (w_accept) begin
        r_ext_id <= bus.out_id;
        r_fee    <= w_fee;
      end
      r_err[ERR_BAR_TO]  <= w_timeout;
      r_err[ERR_BAD_TKT] <= w_bad;
    end
  end

  assign bus.bar_in    = w_bar_in;
  assign bus.tkt_valid = r_tkt_valid;
  assign bus.tkt_id    = r_tkt_id;
  assign bus.fee       = r_fee;
  assign bus.fee_valid = w_fee_valid;
  assign bus.bar_out   = w_bar_out;
  assign bus.free_cnt  = w_free_cnt;
  assign bus.full      = w_full;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_car_park_ctrl.sv
// Self-checking bench for car_park_ctrl: directed table, corner sequences, random traffic vs. slot model.
module tb_car_park_ctrl;
  localparam int unsigned N      = 8;
  localparam int unsigned TW     = 16;
  localparam int unsigned RATE   = 1;
  localparam int unsigned BAR_TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  car_park_ctrl_if #(.N_SLOTS(N), .FEE_W(24)) bus  ();
  car_park_ctrl_if #(.N_SLOTS(N), .FEE_W(24)) bus4 ();

  car_park_ctrl #(.N_SLOTS(N), .TIME_W(TW), .RATE(RATE), .FEE_W(24), .BAR_TO(BAR_TO)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  car_park_ctrl #(.N_SLOTS(N), .TIME_W(4), .RATE(1), .FEE_W(24), .BAR_TO(BAR_TO)) u_dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which places are taken, when each car arrived, current time
  bit ref_valid [N];
  int ref_t     [N];
  int ref_time  = 0;

  typedef struct {
    bit is_exit;
    int id;
    int pre_ticks;
    int exp_val;   // entry: ticket id (-1 = refused); exit: fee (-1 = invalid ticket)
    int exp_free;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    if (n > 0) begin
      bus.tick = 1'b1;
      repeat (n) step();
      bus.tick = 1'b0;
      ref_time += n;
    end
  endtask

  function automatic int ref_free();
    int c = 0;
    for (int i = 0; i < N; i++) if (!ref_valid[i]) c++;
    return c;
  endfunction

  function automatic int ref_lowest();
    for (int i = 0; i < N; i++) if (!ref_valid[i]) return i;
    return -1;
  endfunction

  function automatic int ref_fee(input int id);
    int e;
    longint p;
    e = (ref_time - ref_t[id]) & ((1 << TW) - 1);
    if (e == 0) e = 1;
    p = longint'(e) * longint'(RATE);
    if (p > 64'hFFFFFF) p = 64'hFFFFFF;
    return int'(p);
  endfunction

  task automatic do_entry(input int exp_id, input int exp_free);
    bus.in_req = 1'b1;
    step();
    if (exp_id < 0) begin
      chk("refused_tkt_valid", bus.tkt_valid, 0);
      chk("refused_bar_in", bus.bar_in, 0);
    end else begin
      chk("entry_tkt_valid", bus.tkt_valid, 1);
      chk("entry_tkt_id", bus.tkt_id, exp_id);
      chk("entry_bar_in_open", bus.bar_in, 1);
      ref_valid[exp_id] = 1'b1;
      ref_t[exp_id]     = ref_time;
      bus.in_pass = 1'b1;
      step();
      bus.in_pass = 1'b0;
      chk("entry_bar_in_closed", bus.bar_in, 0);
      chk("entry_tkt_pulse_end", bus.tkt_valid, 0);
    end
    chk("entry_free_cnt", bus.free_cnt, exp_free);
    chk("entry_full", bus.full, (exp_free == 0) ? 1 : 0);
    bus.in_req = 1'b0;
    step();
  endtask

  task automatic do_exit(input int id, input int exp_fee, input int exp_free);
    bus.out_req = 1'b1;
    bus.out_id  = 3'(id);
    step();
    if (exp_fee < 0) begin
      chk("bad_tkt_err", bus.err, 2);
      chk("bad_tkt_fee_valid", bus.fee_valid, 0);
      step();
      chk("bad_tkt_err_end", bus.err, 0);
      chk("bad_tkt_bar_out", bus.bar_out, 0);
    end else begin
      chk("exit_fee_valid", bus.fee_valid, 1);
      chk("exit_fee", bus.fee, exp_fee);
      step();
      chk("exit_fee_held", bus.fee, exp_fee);
      bus.pay = 1'b1;
      step();
      bus.pay = 1'b0;
      chk("exit_bar_out_open", bus.bar_out, 1);
      chk("exit_fee_valid_drop", bus.fee_valid, 0);
      bus.out_pass = 1'b1;
      step();
      bus.out_pass = 1'b0;
      chk("exit_bar_out_closed", bus.bar_out, 0);
      ref_valid[id] = 1'b0;
    end
    chk("exit_free_cnt", bus.free_cnt, exp_free);
    bus.out_req = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    {bus.tick, bus.in_req, bus.in_pass, bus.out_req, bus.pay, bus.out_pass} = '0;
    bus.out_id = '0;
    {bus4.tick, bus4.in_req, bus4.in_pass, bus4.out_req, bus4.pay, bus4.out_pass} = '0;
    bus4.out_id = '0;
    for (int i = 0; i < N; i++) begin ref_valid[i] = 1'b0; ref_t[i] = 0; end

    rst = 1'b1;
    repeat (3) step();
    chk("rst_bar_in", bus.bar_in, 0);
    chk("rst_tkt_valid", bus.tkt_valid, 0);
    chk("rst_tkt_id", bus.tkt_id, 0);
    chk("rst_fee", bus.fee, 0);
    chk("rst_fee_valid", bus.fee_valid, 0);
    chk("rst_bar_out", bus.bar_out, 0);
    chk("rst_free_cnt", bus.free_cnt, 8);
    chk("rst_full", bus.full, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    step();

    // Directed table
    tbl.push_back('{0, 0, 5, 0, 7});
    tbl.push_back('{1, 0, 20, 20, 8});
    for (int k = 0; k < 8; k++) tbl.push_back('{0, 0, 0, k, 7 - k});
    tbl.push_back('{0, 0, 0, -1, 0});
    tbl.push_back('{1, 3, 3, 3, 1});
    tbl.push_back('{0, 0, 0, 3, 0});
    tbl.push_back('{1, 5, 2, 5, 1});
    tbl.push_back('{1, 5, 0, -1, 1});
    tbl.push_back('{0, 0, 1, 5, 0});
    tbl.push_back('{1, 5, 0, 1, 1});
    foreach (tbl[i]) begin
      advance(tbl[i].pre_ticks);
      if (tbl[i].is_exit) do_exit(tbl[i].id, tbl[i].exp_val, tbl[i].exp_free);
      else                do_entry(tbl[i].exp_val, tbl[i].exp_free);
    end

    // Entry bar timeout releases the slot
    bus.in_req = 1'b1;
    step();
    chk("to_tkt_id", bus.tkt_id, 5);
    chk("to_free_cnt_taken", bus.free_cnt, 0);
    repeat (BAR_TO - 1) step();
    chk("to_bar_still_open", bus.bar_in, 1);
    chk("to_no_err_yet", bus.err, 0);
    step();
    chk("to_bar_closed", bus.bar_in, 0);
    chk("to_err0", bus.err, 1);
    chk("to_slot_released", bus.free_cnt, 1);
    step();
    chk("to_err_pulse_end", bus.err, 0);
    chk("to_hold_bar_closed", bus.bar_in, 0);
    bus.in_req = 1'b0;
    step();
    ref_valid[5] = 1'b0;
    do_exit(5, -1, 1);

    // Same-cycle allocate/release with a coincident tick
    bus.out_req = 1'b1;
    bus.out_id  = 3'd2;
    step();
    chk("sc_fee", bus.fee, 6);
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    chk("sc_bar_out", bus.bar_out, 1);
    bus.in_req   = 1'b1;
    bus.out_pass = 1'b1;
    bus.tick     = 1'b1;
    step();
    bus.out_pass = 1'b0;
    bus.tick     = 1'b0;
    chk("sc_tkt_valid", bus.tkt_valid, 1);
    chk("sc_pre_cycle_alloc", bus.tkt_id, 5);
    chk("sc_free_unchanged", bus.free_cnt, 1);
    ref_valid[2] = 1'b0;
    ref_valid[5] = 1'b1;
    ref_t[5]     = ref_time;
    ref_time     = ref_time + 1;
    bus.in_pass = 1'b1;
    bus.out_req = 1'b0;
    step();
    bus.in_pass = 1'b0;
    bus.in_req  = 1'b0;
    step();
    advance(3);
    do_exit(5, 4, 2);
    do_entry(2, 1);

    // Time counter wrap on the 4-bit instance; abort before payment keeps the slot
    bus4.tick = 1'b1;
    repeat (14) step();
    bus4.tick   = 1'b0;
    bus4.in_req = 1'b1;
    step();
    chk("w4_tkt_id", bus4.tkt_id, 0);
    bus4.in_pass = 1'b1;
    step();
    bus4.in_pass = 1'b0;
    bus4.in_req  = 1'b0;
    step();
    bus4.tick = 1'b1;
    repeat (4) step();
    bus4.tick    = 1'b0;
    bus4.out_req = 1'b1;
    bus4.out_id  = 3'd0;
    step();
    chk("w4_fee_wrap", bus4.fee, 4);
    chk("w4_fee_valid", bus4.fee_valid, 1);
    bus4.out_req = 1'b0;
    step();
    chk("w4_abort_fee_valid", bus4.fee_valid, 0);
    chk("w4_abort_keeps_slot", bus4.free_cnt, 7);

    // Random traffic against the model
    repeat (250) begin
      advance(int'($urandom_range(0, 20)));
      if ($urandom_range(0, 1) == 1) begin
        id = ref_lowest();
        if (id < 0) do_entry(-1, 0);
        else        do_entry(id, ref_free() - 1);
      end else begin
        id = int'($urandom_range(0, N - 1));
        if (ref_valid[id]) do_exit(id, ref_fee(id), ref_free() + 1);
        else               do_exit(id, -1, ref_free());
      end
    end

    // Reset while the exit bar is open
    if (ref_free() == N) do_entry(0, N - 1);
    id = 0;
    for (int i = N - 1; i >= 0; i--) if (ref_valid[i]) id = i;
    bus.out_req = 1'b1;
    bus.out_id  = 3'(id);
    step();
    bus.pay = 1'b1;
    step();
    bus.pay = 1'b0;
    chk("rm_bar_out_open", bus.bar_out, 1);
    rst = 1'b1;
    step();
    chk("rm_bar_out_closed", bus.bar_out, 0);
    chk("rm_free_cnt", bus.free_cnt, 8);
    chk("rm_fee_valid", bus.fee_valid, 0);
    chk("rm_fee", bus.fee, 0);
    rst = 1'b0;
    bus.out_req = 1'b0;
    step();
    for (int i = 0; i < N; i++) ref_valid[i] = 1'b0;
    ref_time = 0;
    do_entry(0, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
